// File: rtl/spi_ram_arbiter.sv
// Purpose: shares the single-port 64x32 SPI register RAM between the SPI read port (A) and the acquisition writer (B).
// Latency: request sampled at edge N -> gnt/RAM access after N+1 -> a_rvalid/a_rdata after N+RD_LAT+2.
// Backpressure: a requester holds req until its gnt pulse; B is forced through after MAX_WAIT lost cycles.
//
// Ports:
//   clk, reset                          system clock, synchronous active-high reset
//   a_req, a_addr                       SPI read request/address
//   a_gnt, a_rdata, a_rvalid, last_addr read grant, returned data, data-valid pulse, last-register flag
//   b_req, b_addr, b_wdata, b_gnt       writer request/address/data and grant
//   ram_addr, ram_wdata, ram_we         RAM command outputs (registered)
//   ram_rdata                           RAM read data, valid RD_LAT cycles after the address
module spi_ram_arbiter #(
    parameter int                   ADDR_SIZE = 6,
    parameter int                   WORD_SIZE = 32,
    parameter int                   RD_LAT    = 2,
    parameter int                   MAX_WAIT  = 4,
    parameter logic [ADDR_SIZE-1:0] LAST_ADDR = 6'h3F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic [ADDR_SIZE-1:0] a_addr,
    output logic                 a_gnt,
    output logic [WORD_SIZE-1:0] a_rdata,
    output logic                 a_rvalid,
    output logic                 last_addr,
    input  logic                 b_req,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_wdata,
    output logic                 b_gnt,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 ram_we,
    input  logic [WORD_SIZE-1:0] ram_rdata
);

    // Requests are captured first; arbitration works on the captured copies.
    logic                 a_req_q;
    logic                 b_req_q;
    logic [ADDR_SIZE-1:0] a_addr_q;
    logic [ADDR_SIZE-1:0] b_addr_q;
    logic [WORD_SIZE-1:0] b_wdata_q;

    logic [3:0]           b_wait;

    // Read tracking: bit 0 is loaded in the same edge the RAM address is driven,
    // so bit RD_LAT lines up with the cycle ram_rdata carries that read's data.
    logic [RD_LAT:0]      pipe_vld;
    logic [RD_LAT:0]      pipe_last;

    logic                 b_force;
    logic                 a_win;
    logic                 b_win;

    always_comb begin
        b_force = 1'b0;
        a_win   = 1'b0;
        b_win   = 1'b0;
        b_force = (b_wait >= 4'(MAX_WAIT));
        // A has priority unless B has been starved long enough.
        a_win   = a_req_q && !(b_req_q && b_force);
        b_win   = b_req_q && !a_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_req_q   <= 1'b0;
            b_req_q   <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
            b_wait    <= 4'd0;
            pipe_vld  <= '0;
            pipe_last <= '0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            a_rvalid  <= 1'b0;
            last_addr <= 1'b0;
            a_rdata   <= '0;
        end else begin
            a_req_q   <= a_req;
            b_req_q   <= b_req;
            a_addr_q  <= a_addr;
            b_addr_q  <= b_addr;
            b_wdata_q <= b_wdata;

            a_gnt     <= a_win;
            b_gnt     <= b_win;
            ram_we    <= b_win;

            // Address and write data hold when the RAM is idle.
            if (a_win) begin
                ram_addr <= a_addr_q;
            end else if (b_win) begin
                ram_addr  <= b_addr_q;
                ram_wdata <= b_wdata_q;
            end

            if (b_win || !b_req_q) begin
                b_wait <= 4'd0;
            end else if (b_wait != 4'hF) begin
                b_wait <= b_wait + 4'd1;
            end

            pipe_vld  <= {pipe_vld[RD_LAT-1:0], a_win};
            pipe_last <= {pipe_last[RD_LAT-1:0], a_win && (a_addr_q == LAST_ADDR)};

            a_rvalid  <= pipe_vld[RD_LAT];
            last_addr <= pipe_last[RD_LAT];
            if (pipe_vld[RD_LAT]) begin
                a_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req;
    logic [5:0]  a_addr;
    logic        a_gnt;
    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        last_addr;
    logic        b_req;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    int checks;
    int failures;

    spi_ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_gnt     (a_gnt),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .last_addr (last_addr),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 2-cycle read latency, write on the edge ram_we is seen.
    // Contents are (re)initialised while reset is high.
    logic [31:0] mem [64];
    logic [31:0] rd_s1;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                if (i == 0)      mem[i] <= 32'hCAFE0000;
                else if (i == 5) mem[i] <= 32'hDEADBEEF;
                else             mem[i] <= {4{8'(i)}};
            end
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_s1     <= mem[ram_addr];
        ram_rdata <= rd_s1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        a_req;
        logic [5:0]  a_addr;
        logic        b_req;
        logic [5:0]  b_addr;
        logic [31:0] b_wdata;
        logic [74:0] exp;   // {a_gnt,b_gnt,ram_we,ram_addr,ram_wdata,a_rvalid,a_rdata,last_addr}
    } vec_t;

    function automatic vec_t mk(input logic ar, input logic [5:0] aa, input logic br,
                                input logic [5:0] ba, input logic [31:0] bw,
                                input logic ag, input logic bg, input logic we,
                                input logic [5:0] ra, input logic [31:0] rw,
                                input logic rv, input logic [31:0] rd, input logic la);
        vec_t v;
        v.a_req   = ar;
        v.a_addr  = aa;
        v.b_req   = br;
        v.b_addr  = ba;
        v.b_wdata = bw;
        v.exp     = {ag, bg, we, ra, rw, rv, rd, la};
        return v;
    endfunction

    task automatic idle(input int n);
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs [19];

    initial begin
        int grants;
        int bpos;
        int a_cnt;
        int b_cnt;
        int both_cnt;
        int stray;
        int lat;
        logic [6:0] we_addr;

        checks   = 0;
        failures = 0;

        // Row i inputs are sampled at table edge i; expected outputs are seen right after that edge.
        vecs[0]  = mk(1, 6'h05, 0, 6'h00, 32'h0,        0,0,0, 6'h00, 32'h0,        0, 32'hCAFE0000, 0);
        vecs[1]  = mk(0, 6'h00, 0, 6'h00, 32'h0,        1,0,0, 6'h05, 32'h0,        0, 32'hCAFE0000, 0);
        vecs[2]  = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h05, 32'h0,        0, 32'hCAFE0000, 0);
        vecs[3]  = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h05, 32'h0,        0, 32'hCAFE0000, 0);
        vecs[4]  = mk(1, 6'h3D, 0, 6'h00, 32'h0,        0,0,0, 6'h05, 32'h0,        1, 32'hDEADBEEF, 0);
        vecs[5]  = mk(1, 6'h3E, 0, 6'h00, 32'h0,        1,0,0, 6'h3D, 32'h0,        0, 32'hDEADBEEF, 0);
        vecs[6]  = mk(1, 6'h3F, 0, 6'h00, 32'h0,        1,0,0, 6'h3E, 32'h0,        0, 32'hDEADBEEF, 0);
        vecs[7]  = mk(0, 6'h00, 0, 6'h00, 32'h0,        1,0,0, 6'h3F, 32'h0,        0, 32'hDEADBEEF, 0);
        vecs[8]  = mk(0, 6'h00, 1, 6'h20, 32'h55AA55AA, 0,0,0, 6'h3F, 32'h0,        1, 32'h3D3D3D3D, 0);
        vecs[9]  = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,1,1, 6'h20, 32'h55AA55AA, 1, 32'h3E3E3E3E, 0);
        vecs[10] = mk(1, 6'h20, 0, 6'h00, 32'h0,        0,0,0, 6'h20, 32'h55AA55AA, 1, 32'h3F3F3F3F, 1);
        vecs[11] = mk(0, 6'h00, 0, 6'h00, 32'h0,        1,0,0, 6'h20, 32'h55AA55AA, 0, 32'h3F3F3F3F, 0);
        vecs[12] = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h20, 32'h55AA55AA, 0, 32'h3F3F3F3F, 0);
        vecs[13] = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h20, 32'h55AA55AA, 0, 32'h3F3F3F3F, 0);
        vecs[14] = mk(1, 6'h07, 1, 6'h21, 32'h11111111, 0,0,0, 6'h20, 32'h55AA55AA, 1, 32'h55AA55AA, 0);
        vecs[15] = mk(0, 6'h00, 1, 6'h21, 32'h11111111, 1,0,0, 6'h07, 32'h55AA55AA, 0, 32'h55AA55AA, 0);
        vecs[16] = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,1,1, 6'h21, 32'h11111111, 0, 32'h55AA55AA, 0);
        vecs[17] = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h21, 32'h11111111, 0, 32'h55AA55AA, 0);
        vecs[18] = mk(0, 6'h00, 0, 6'h00, 32'h0,        0,0,0, 6'h21, 32'h11111111, 1, 32'h07070707, 0);

        // Reset held with both requests high: everything stays zero.
        reset   = 1'b1;
        a_req   = 1'b1;
        b_req   = 1'b1;
        a_addr  = 6'h00;
        b_addr  = 6'h00;
        b_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_outputs_%0d", i),
                  {a_gnt, b_gnt, a_rvalid, last_addr, ram_we, ram_addr, ram_wdata, a_rdata}, '0);
        end

        // Release: request sampled at the first free edge, grant one edge later.
        reset = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;
        check("release_no_gnt_yet", {a_gnt, b_gnt}, 2'b00);
        a_req = 1'b0;
        @(posedge clk);
        #1;
        check("release_first_a_gnt", {a_gnt, b_gnt, ram_we, ram_addr}, {3'b100, 6'h00});
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("release_read_data", {a_rvalid, a_rdata, last_addr}, {1'b1, 32'hCAFE0000, 1'b0});
        idle(2);

        // Cycle-by-cycle vectors: single read, burst to last address, write, read-after-write, contention.
        foreach (vecs[i]) begin
            a_req   = vecs[i].a_req;
            a_addr  = vecs[i].a_addr;
            b_req   = vecs[i].b_req;
            b_addr  = vecs[i].b_addr;
            b_wdata = vecs[i].b_wdata;
            @(posedge clk);
            #1;
            check($sformatf("vec_%0d", i),
                  {a_gnt, b_gnt, ram_we, ram_addr, ram_wdata, a_rvalid, a_rdata, last_addr},
                  vecs[i].exp);
        end
        idle(4);

        // Starvation guard: B forced through on the 5th arbitration cycle.
        a_addr  = 6'h01;
        b_addr  = 6'h10;
        b_wdata = 32'h12345678;
        a_req   = 1'b1;
        b_req   = 1'b1;
        grants  = 0;
        bpos    = 0;
        we_addr = '0;
        for (int i = 0; i < 12 && bpos == 0; i++) begin
            @(posedge clk);
            #1;
            if (a_gnt || b_gnt) grants++;
            if (b_gnt) begin
                bpos    = grants;
                we_addr = {ram_we, ram_addr};
                b_req   = 1'b0;
            end
        end
        check("starve_b_gnt_position", 128'(bpos), 128'd5);
        check("starve_b_write_cmd", we_addr, {1'b1, 6'h10});
        @(posedge clk);
        #1;
        check("starve_a_resumes", {a_gnt, b_gnt}, 2'b10);
        a_req = 1'b0;
        idle(3);
        check("starve_ram_written", mem[6'h10], 32'h12345678);
        idle(4);

        // Fairness: 20 arbitration cycles of continuous contention.
        a_addr  = 6'h02;
        b_addr  = 6'h11;
        b_wdata = 32'hA5A5A5A5;
        a_req   = 1'b1;
        b_req   = 1'b1;
        a_cnt   = 0;
        b_cnt   = 0;
        both_cnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (a_gnt) a_cnt++;
            if (b_gnt) b_cnt++;
            if (a_gnt && b_gnt) both_cnt++;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("fair_a_gnt_count", 128'(a_cnt), 128'd16);
        check("fair_b_gnt_count", 128'(b_cnt), 128'd4);
        check("fair_no_double_gnt", 128'(both_cnt), 128'd0);
        idle(6);

        // Reset one cycle before read data is due: the read is dropped.
        a_addr = 6'h3F;
        a_req  = 1'b1;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("flight_reset_drops_gnt", {a_gnt, b_gnt, ram_we}, 3'b000);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (a_rvalid || last_addr) stray++;
        end
        check("flight_no_rvalid", 128'(stray), 128'd0);

        // Fresh read of the last address after the reset.
        a_addr = 6'h3F;
        a_req  = 1'b1;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        lat   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (a_rvalid) break;
        end
        check("post_reset_latency", 128'(lat), 128'd4);
        check("post_reset_data", {a_rvalid, a_rdata, last_addr}, {1'b1, 32'h3F3F3F3F, 1'b1});
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
